// File: rtl/pc_gen.sv
// Fetch-stage program counter: reset/exception vectors, eret, branch redirect,
// stall/ready-gated advance, and a circular return-address stack for returns.
module pc_gen #(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
   parameter int          INC       = 4,
   parameter int          RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              ready_i,
   input  logic              exc_i,
   input  logic              eret_i,
   input  logic [ADDR_W-1:0] epc_i,
   input  logic              branchEnable_i,
   input  logic [ADDR_W-1:0] branchAddr_i,
   input  logic              call_i,
   input  logic [ADDR_W-1:0] linkAddr_i,
   input  logic              ret_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pcValid_o,
   output logic              rasEmpty_o,
   output logic              rasOverflow_o
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] EXC_A  = ADDR_W'(EXC_VEC);
   localparam logic [ADDR_W-1:0] INC_A  = ADDR_W'(INC);
   localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              vld_q;
   logic [PTR_W-1:0]  top_q, top_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic              has_top;

   assign has_top = (cnt_q != '0);

   always_comb begin
      pc_d   = pc_q;
      top_d  = top_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      wr_en  = 1'b0;
      wr_idx = top_q;

      if (exc_i)
         pc_d = EXC_A;
      else if (eret_i)
         pc_d = epc_i;
      else if (ret_i)
         pc_d = has_top ? ras_q[top_q] : branchAddr_i;
      else if (branchEnable_i)
         pc_d = branchAddr_i;
      else if (vld_q && ready_i && !stall_i)
         pc_d = pc_q + INC_A;

      if (exc_i) begin
         top_d = '0;
         cnt_d = '0;
      end else if (!eret_i) begin
         if (call_i && ret_i && has_top) begin
            // call+ret: the popped frame is replaced by the new link in place
            wr_en = 1'b1;
         end else if (call_i) begin
            wr_en  = 1'b1;
            wr_idx = top_q + PTR_W'(1);
            top_d  = top_q + PTR_W'(1);
            if (cnt_q == FULL_C)
               ovf_d = 1'b1;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end else if (ret_i && has_top) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RST_A;
         vld_q <= 1'b0;
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         vld_q <= 1'b1;
         top_q <= top_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage needs no reset; count/top gate every read.
   always_ff @(posedge clk) begin
      if (!rst && wr_en)
         ras_q[wr_idx] <= linkAddr_i;
   end

   assign pc_o          = pc_q;
   assign pcValid_o     = vld_q;
   assign rasEmpty_o    = (cnt_q == '0);
   assign rasOverflow_o = ovf_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage and the successor to the fixed 32-bit branch/increment PC. It adds stall and fetch backpressure, exception entry and return, configurable reset and exception vectors, and a small circular return-address stack (RAS) that predicts `jr $ra`-style returns. It sits between the decode/exception logic, which drives the redirects, and the instruction-memory request port, which consumes `pc_o`.

## Interface
- `ADDR_W`, 32: PC width in bits.
- `RESET_VEC`, 0: value loaded into `pc_o` while in reset.
- `EXC_VEC`, 32'h0000_0180: exception entry address, truncated to `ADDR_W`.
- `INC`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset; clock `clk`.
- `stall_i` in 1: hold the sequential advance.
- `ready_i` in 1: fetch consumer accepts the current `pc_o`.
- `exc_i` in 1: take exception.
- `eret_i` in 1: return from exception.
- `epc_i` in `ADDR_W`: eret target.
- `branchEnable_i` in 1: taken branch or jump.
- `branchAddr_i` in `ADDR_W`: branch target; also the fallback target for a return when the RAS is empty.
- `call_i` in 1: push `linkAddr_i` onto the RAS.
- `linkAddr_i` in `ADDR_W`: return address to push.
- `ret_i` in 1: return; pop the RAS and redirect.
- `pc_o` out `ADDR_W`: current fetch address.
- `pcValid_o` out 1: `pc_o` is a valid fetch request.
- `rasEmpty_o` out 1: RAS count is 0.
- `rasOverflow_o` out 1: sticky; a push hit a full RAS.

## Operation
- **Next-PC priority**, highest first:
  - `rst` → `RESET_VEC`
  - `exc_i` → `EXC_VEC`
  - `eret_i` → `epc_i`
  - `ret_i` → RAS top, or `branchAddr_i` if the RAS is empty
  - `branchEnable_i` → `branchAddr_i`
  - advance → `pc_o + INC`
  - otherwise → hold
- Advance happens only when `pcValid_o && ready_i && !stall_i`.
- Redirects (exc, eret, ret, branch) override `stall_i` and `ready_i`; a redirect is never lost.
- Arithmetic is modulo 2^`ADDR_W`; `pc_o + INC` wraps silently. Targets are loaded unmodified, with no alignment masking.
- **RAS state:** circular buffer with `top` pointer and saturating `count` in 0..`RAS_DEPTH`.
- **Push** (`call_i`, no exc/eret that cycle):
  - Write `linkAddr_i` at `top+1`; `top` increments.
  - `count` increments and saturates at `RAS_DEPTH`.
  - Push while full overwrites the oldest entry and sets `rasOverflow_o`.
- **Pop** (`ret_i`, no exc/eret, count>0):
  - Redirect to `ras[top]`.
  - `top` decrements; `count` decrements.
  - Pop with count=0 does not change RAS state and redirects to `branchAddr_i`.
- **Simultaneous `call_i` and `ret_i`:**
  - Redirect to the old top.
  - The old top is replaced in place by `linkAddr_i`; `count` is unchanged. If count=0, perform the push only.
- **`exc_i`:** clears the RAS (count=0, top=0); `rasOverflow_o` is unaffected.
- **`eret_i`:** leaves the RAS untouched and ignores `call_i` and `ret_i`.
- **`rst`:** clears count, top and `rasOverflow_o`. RAS storage contents are don't-care.

## Timing
- **Reset values:**
  - `pc_o` = `RESET_VEC`
  - `pcValid_o` = 0
  - `rasEmpty_o` = 1
  - `rasOverflow_o` = 0
- **`pcValid_o`:** registered. It is 1 from the first edge with `rst`=0 and stays 1 until the next reset.
- **Reset release:** first valid fetch is `RESET_VEC` in the cycle after that first edge.
- **Redirect latency:** 1 cycle. A redirect input sampled at edge N puts the target on `pc_o` after edge N.
- **Outputs:** all registered, with no combinational input→output paths. `rasEmpty_o` reflects count after the edge.
- **Reset mid-operation:** overrides every other input on that edge.

## Test plan
- **Reset and advance:** `rst` high 2 cycles, then low, `ready_i`=1 → `pc_o` sequence 0, 4, 8, 12; `pcValid_o` 0 during reset, then 1.
- **Stall vs redirect:** `ready_i`=1, `stall_i`=1 at pc=0x10 → `pc_o` holds 0x10. Then `branchEnable_i`=1, `branchAddr_i`=0x400 with `stall_i` still 1 → `pc_o`=0x400 next cycle.
- **Priority:** `exc_i`, `eret_i` and `branchEnable_i` asserted together → `pc_o`=0x180. Next cycle `eret_i`, `epc_i`=0x88 → `pc_o`=0x88.
- **RAS round-trip:**
  - Push 0x100, 0x200, 0x300, then three `ret_i` → `pc_o` goes 0x300, 0x200, 0x100; `rasEmpty_o`=1.
  - Fourth `ret_i` with `branchAddr_i`=0x50 → `pc_o`=0x50.
- **RAS overflow:** `RAS_DEPTH`=4, push 0x10, 0x20, 0x30, 0x40, 0x50 → `rasOverflow_o`=1. Four pops → 0x50, 0x40, 0x30, 0x20, then empty.
- **Simultaneous and wrap:**
  - `call_i`+`ret_i` with top 0x40 and `linkAddr_i`=0x99 → `pc_o`=0x40, top becomes 0x99.
  - `ADDR_W`=8 at pc=0xFC advance → `pc_o`=0x00.
